cpu_mem_sequencer: RTL and testbench
====================================

Name: cpu_mem_sequencer

Overview:
- Clocked read/write handshake engine between the CPU control FSM and the motherboard controller.
- The CPU FSM "calls" a READ or WRITE with a return state; the block runs a 4-phase handshake on mobo_ctrl/mobo_stat and strobes data capture.
- On completion it hands the return state back with a one-cycle done pulse.
- Address and data registers stay in the CPU datapath; this block only sequences control.

Parameters:
- WORD_WIDTH, 16, width of mobo_ctrl and mobo_stat.
- STATE_WIDTH, 8, width of the CPU return-state code.
- TIMEOUT, 16, maximum transaction cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low; clock clk.
- call_valid  in  1  start request, sampled in IDLE only.
- call_op  in  1  0=READ, 1=WRITE.
- call_ret  in  STATE_WIDTH  CPU state to resume after completion.
- mobo_stat  in  WORD_WIDTH  motherboard status: 0=IDLE, 1=BUSY, 2=DONE; any other value is treated as BUSY.
- mobo_ctrl  out  WORD_WIDTH  command: 0=IDLE, 1=READ, 2=WRITE.
- busy  out  1  high whenever not in IDLE.
- data_latch  out  1  combinational strobe telling the CPU to load mobodat_in.
- done  out  1  one-cycle completion pulse.
- ret_state  out  STATE_WIDTH  latched call_ret; valid while done=1.
- err  out  1  high with done when the transaction timed out.
- dbg_enable  out  1  high in every non-IDLE state (debug print hook).

Behaviour:
- Reset (rst=0 at a clock edge):
  - state goes to IDLE; op, ret, counter and err flag clear.
  - All outputs read 0 the following cycle.
  - Reset mid-transaction aborts immediately: mobo_ctrl returns to IDLE and there is no done pulse.
- States are IDLE, REQ, RELEASE, FINISH. mobo_ctrl, busy, done and dbg_enable decode from the state register (Moore). data_latch is Mealy.
- IDLE:
  - mobo_ctrl=0.
  - If call_valid=1, latch call_op and call_ret, clear counter and err, go to REQ.
- REQ:
  - mobo_ctrl=1 for READ, 2 for WRITE.
  - If mobo_stat==2: go to RELEASE; for READ only, data_latch=1 in this same cycle.
  - Otherwise counter increments.
  - If TIMEOUT!=0 and counter reaches TIMEOUT-1 without DONE: set err and go to RELEASE. data_latch stays 0.
- RELEASE:
  - mobo_ctrl=0.
  - Stay until mobo_stat==0, then go to FINISH.
  - The counter keeps running; a timeout here also sets err and goes to FINISH.
- FINISH: done=1, ret_state=latched ret, err valid; go to IDLE.
- Latency with immediate responses: call_valid at cycle 0, REQ at cycle 1, RELEASE at cycle 2, done at cycle 3. Minimum 4 cycles from call to next accepted call.
- call_valid while busy=1 is ignored (no queueing); the caller retries after done.
- The latched op and ret are stable for the whole transaction; call_* changes after acceptance have no effect.
- mobo_stat==2 arriving in RELEASE (stale DONE) keeps the block waiting; it never re-latches data.
- ret_state holds its last value after done.

Decomposition:
- Shared package (cpu_pkg) holds:
  - mobo_ctrl codes: CTRL_IDLE/READ/WRITE;
  - mobo_stat codes: STAT_IDLE/BUSY/DONE;
  - the op enum;
  - the sequencer state enum;
  - the WORD_WIDTH and STATE_WIDTH defaults.
- One natural sub-module, seq_timeout_counter: clear, enable and terminal-count flag.
- The FSM and output decode stay in cpu_mem_sequencer.

Test Plan:
- READ happy path:
  - call_op=0, call_ret=0x42; mobo_stat=2 at cycle 1 and 0 at cycle 2.
  - Expect mobo_ctrl=1 at cycle 1, data_latch=1 at cycle 1, mobo_ctrl=0 at cycle 2.
  - Expect done=1 and ret_state=0x42 at cycle 3, err=0.
- WRITE with slow device:
  - mobo_stat=1 for 5 cycles, then 2, then 0.
  - Expect mobo_ctrl=2 for 6 cycles and data_latch never 1.
  - Expect done 2 cycles after DONE, err=0.
- Timeout (TIMEOUT=16):
  - READ with mobo_stat stuck at 1.
  - Expect REQ to exit after 16 cycles with data_latch=0, then RELEASE with mobo_ctrl=0.
  - Expect done=1 and err=1 once stat=0.
- Busy rejection:
  - Pulse call_valid with call_ret=0x11 while busy, during a transaction started with ret=0x22.
  - Expect ret_state=0x22 at done and no second transaction.
- Reset mid-operation:
  - Drive rst=0 while in REQ.
  - Expect next cycle mobo_ctrl=0, busy=0, done=0; a new call after rst=1 completes normally.
- Stale DONE in RELEASE:
  - Hold mobo_stat=2 for 3 extra cycles.
  - Expect the block to stay in RELEASE with a single data_latch pulse, done only after stat=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared codes and types for the CPU <-> motherboard memory sequencer.
// Bus command/status encodings are plain integers cast to the bus width at use.
package cpu_pkg;

   localparam int unsigned WORD_WIDTH_DEF  = 16;
   localparam int unsigned STATE_WIDTH_DEF = 8;

   localparam int unsigned CTRL_IDLE  = 0;
   localparam int unsigned CTRL_READ  = 1;
   localparam int unsigned CTRL_WRITE = 2;

   localparam int unsigned STAT_IDLE = 0;
   localparam int unsigned STAT_BUSY = 1;
   localparam int unsigned STAT_DONE = 2;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_REQ,
      SEQ_RELEASE,
      SEQ_FINISH
   } seq_state_e;

   function automatic int unsigned ctrl_for_op(input op_e op);
      return (op == OP_WRITE) ? CTRL_WRITE : CTRL_READ;
   endfunction

endpackage

// File: rtl/cpu_mem_sequencer_if.sv
// Call/return handshake from the CPU FSM plus the motherboard ctrl/stat pair.
// master = CPU and motherboard side, slave = the sequencer.
interface cpu_mem_sequencer_if #(
   parameter int unsigned WORD_WIDTH  = 16,
   parameter int unsigned STATE_WIDTH = 8
);
   logic                   call_valid;
   logic                   call_op;
   logic [STATE_WIDTH-1:0] call_ret;
   logic [WORD_WIDTH-1:0]  mobo_stat;
   logic [WORD_WIDTH-1:0]  mobo_ctrl;
   logic                   busy;
   logic                   data_latch;
   logic                   done;
   logic [STATE_WIDTH-1:0] ret_state;
   logic                   err;
   logic                   dbg_enable;

   modport master (
      output call_valid, call_op, call_ret, mobo_stat,
      input  mobo_ctrl, busy, data_latch, done, ret_state, err, dbg_enable
   );

   modport slave (
      input  call_valid, call_op, call_ret, mobo_stat,
      output mobo_ctrl, busy, data_latch, done, ret_state, err, dbg_enable
   );
endinterface

// File: rtl/seq_timeout_counter.sv
// Transaction cycle counter, wrapping at TIMEOUT; tc marks the last count.
// TIMEOUT=0 keeps tc low permanently.
module seq_timeout_counter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);
   localparam int unsigned    CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   logic [CW-1:0] count;

   // Wrapping (rather than saturating) gives RELEASE a fresh budget after a REQ timeout.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   assign tc = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/cpu_mem_sequencer.sv
// Call/return engine running the 4-phase READ/WRITE handshake with the motherboard.
// Moore outputs are registered alongside the state; data_latch is the only Mealy output.
module cpu_mem_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned WORD_WIDTH  = WORD_WIDTH_DEF,
   parameter int unsigned STATE_WIDTH = STATE_WIDTH_DEF,
   parameter int unsigned TIMEOUT     = 16
) (
   input logic               clk,
   input logic               rst,
   cpu_mem_sequencer_if.slave bus
);
   seq_state_e             state;
   op_e                    op;
   logic [STATE_WIDTH-1:0] ret;
   logic                   err_flag;
   logic [WORD_WIDTH-1:0]  mobo_ctrl_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;
   logic                   dbg_q;

   logic stat_done;
   logic stat_idle;
   logic accept;
   logic cnt_en;
   logic tc;

   assign stat_done = (bus.mobo_stat == WORD_WIDTH'(STAT_DONE));
   assign stat_idle = (bus.mobo_stat == WORD_WIDTH'(STAT_IDLE));
   assign accept    = (state == SEQ_IDLE) && bus.call_valid;
   assign cnt_en    = ((state == SEQ_REQ) && !stat_done) || (state == SEQ_RELEASE);

   seq_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept),
      .enable (cnt_en),
      .tc     (tc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= SEQ_IDLE;
         op          <= OP_READ;
         ret         <= '0;
         err_flag    <= 1'b0;
         mobo_ctrl_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         dbg_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state)
            SEQ_IDLE: begin
               if (bus.call_valid) begin
                  op          <= op_e'(bus.call_op);
                  ret         <= bus.call_ret;
                  err_flag    <= 1'b0;
                  mobo_ctrl_q <= WORD_WIDTH'(ctrl_for_op(op_e'(bus.call_op)));
                  busy_q      <= 1'b1;
                  dbg_q       <= 1'b1;
                  state       <= SEQ_REQ;
               end
            end
            SEQ_REQ: begin
               // DONE wins over a coincident timeout so read data is never dropped.
               if (stat_done) begin
                  mobo_ctrl_q <= WORD_WIDTH'(CTRL_IDLE);
                  state       <= SEQ_RELEASE;
               end else if (tc) begin
                  err_flag    <= 1'b1;
                  mobo_ctrl_q <= WORD_WIDTH'(CTRL_IDLE);
                  state       <= SEQ_RELEASE;
               end
            end
            SEQ_RELEASE: begin
               if (stat_idle) begin
                  done_q <= 1'b1;
                  err_q  <= err_flag;
                  state  <= SEQ_FINISH;
               end else if (tc) begin
                  err_flag <= 1'b1;
                  done_q   <= 1'b1;
                  err_q    <= 1'b1;
                  state    <= SEQ_FINISH;
               end
            end
            SEQ_FINISH: begin
               busy_q <= 1'b0;
               dbg_q  <= 1'b0;
               state  <= SEQ_IDLE;
            end
         endcase
      end
   end

   assign bus.mobo_ctrl  = mobo_ctrl_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.dbg_enable = dbg_q;
   assign bus.ret_state  = ret;
   assign bus.data_latch = (state == SEQ_REQ) && (op == OP_READ) && stat_done;

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Directed scenarios plus a randomized run against a cycle-budget reference model.
module tb_cpu_mem_sequencer;
   import cpu_pkg::*;

   localparam int unsigned WW = 16;
   localparam int unsigned SW = 8;
   localparam int unsigned TO = 16;

   typedef logic [28:0] obs_t;  // {ctrl[15:0], busy, latch, done, err, dbg, ret[7:0]}

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [7:0] hold;

   always #5 clk = ~clk;

   cpu_mem_sequencer_if #(.WORD_WIDTH(WW), .STATE_WIDTH(SW)) bus ();

   cpu_mem_sequencer #(
      .WORD_WIDTH  (WW),
      .STATE_WIDTH (SW),
      .TIMEOUT     (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic obs_t mk(input int unsigned c, input logic [4:0] f, input logic [7:0] r);
      return {16'(c), f, r};
   endfunction

   function automatic obs_t obs();
      return {bus.mobo_ctrl, bus.busy, bus.data_latch, bus.done, bus.err, bus.dbg_enable, bus.ret_state};
   endfunction

   task automatic run_cycle(input logic cv, input logic op, input logic [7:0] r,
                            input logic [15:0] st, output obs_t o);
      bus.call_valid = cv;
      bus.call_op    = op;
      bus.call_ret   = r;
      bus.mobo_stat  = st;
      @(negedge clk);
      o = obs();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t o;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b1, 1'b1, 8'hA5, 16'd2, o);
         if (i > 0) begin
            n_checks++;
            if (o !== mk(0, 5'b00000, 8'h00)) begin
               n_fail++;
               $display("FAIL reset cycle %0d: got 0x%h expected 0x%h", i, o, mk(0, 5'b00000, 8'h00));
            end
         end
      end
      rst  = 1'b1;
      hold = 8'h00;
   endtask

   task automatic test_read_happy();
      obs_t o, e;
      logic cv;
      logic [15:0] st;
      for (int c = 0; c < 5; c++) begin
         cv = (c == 0);
         st = (c == 1) ? 16'd2 : 16'd0;
         case (c)
            0:       e = mk(0, 5'b00000, hold);
            1:       e = mk(1, 5'b11001, 8'h42);
            2:       e = mk(0, 5'b10001, 8'h42);
            3:       e = mk(0, 5'b10101, 8'h42);
            default: e = mk(0, 5'b00000, 8'h42);
         endcase
         run_cycle(cv, 1'b0, 8'h42, st, o);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL read_happy cycle %0d: got 0x%h expected 0x%h", c, o, e);
         end
      end
      hold = 8'h42;
   endtask

   task automatic test_write_slow();
      obs_t o, e;
      logic [15:0] st;
      int n_wr = 0, n_latch = 0;
      for (int c = 0; c < 10; c++) begin
         st = (c >= 1 && c <= 5) ? 16'd1 : (c == 6) ? 16'd2 : 16'd0;
         if (c == 0)      e = mk(0, 5'b00000, hold);
         else if (c <= 6) e = mk(2, 5'b10001, 8'h5A);
         else if (c == 7) e = mk(0, 5'b10001, 8'h5A);
         else if (c == 8) e = mk(0, 5'b10101, 8'h5A);
         else             e = mk(0, 5'b00000, 8'h5A);
         run_cycle(c == 0, 1'b1, 8'h5A, st, o);
         if (o[28:13] == 16'd2) n_wr++;
         if (o[11]) n_latch++;
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL write_slow cycle %0d: got 0x%h expected 0x%h", c, o, e);
         end
      end
      n_checks++;
      if (n_wr !== 6 || n_latch !== 0) begin
         n_fail++;
         $display("FAIL write_slow counts: ctrl=2 cycles %0d latch pulses %0d, expected 6 and 0", n_wr, n_latch);
      end
      hold = 8'h5A;
   endtask

   task automatic test_timeout();
      obs_t o, e;
      for (int c = 0; c < 23; c++) begin
         if (c == 0)       e = mk(0, 5'b00000, hold);
         else if (c <= 16) e = mk(1, 5'b10001, 8'h3C);
         else if (c <= 20) e = mk(0, 5'b10001, 8'h3C);
         else if (c == 21) e = mk(0, 5'b10111, 8'h3C);
         else              e = mk(0, 5'b00000, 8'h3C);
         run_cycle(c == 0, 1'b0, 8'h3C, (c >= 1 && c <= 19) ? 16'd1 : 16'd0, o);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL req_timeout cycle %0d: got 0x%h expected 0x%h", c, o, e);
         end
      end
      hold = 8'h3C;
   endtask

   task automatic test_release_timeout();
      obs_t o, e;
      logic [15:0] st;
      for (int c = 0; c < 20; c++) begin
         st = (c == 0) ? 16'd0 : (c == 1) ? 16'd2 : 16'd1;
         if (c == 0)       e = mk(0, 5'b00000, hold);
         else if (c == 1)  e = mk(1, 5'b11001, 8'h5C);
         else if (c <= 17) e = mk(0, 5'b10001, 8'h5C);
         else if (c == 18) e = mk(0, 5'b10111, 8'h5C);
         else              e = mk(0, 5'b00000, 8'h5C);
         run_cycle(c == 0, 1'b0, 8'h5C, st, o);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL release_timeout cycle %0d: got 0x%h expected 0x%h", c, o, e);
         end
      end
      hold = 8'h5C;
   endtask

   task automatic test_busy_reject();
      obs_t o, e;
      logic [15:0] st;
      for (int c = 0; c < 8; c++) begin
         st = (c == 1) ? 16'd1 : (c == 2) ? 16'd2 : 16'd0;
         case (c)
            0:       e = mk(0, 5'b00000, hold);
            1:       e = mk(1, 5'b10001, 8'h22);
            2:       e = mk(1, 5'b11001, 8'h22);
            3:       e = mk(0, 5'b10001, 8'h22);
            4:       e = mk(0, 5'b10101, 8'h22);
            default: e = mk(0, 5'b00000, 8'h22);
         endcase
         if (c == 0) run_cycle(1'b1, 1'b0, 8'h22, st, o);
         else        run_cycle(c == 1, 1'b1, 8'h11, st, o);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL busy_reject cycle %0d: got 0x%h expected 0x%h", c, o, e);
         end
      end
      hold = 8'h22;
   endtask

   task automatic test_reset_mid();
      obs_t o, e;
      logic [15:0] st;
      for (int c = 0; c < 9; c++) begin
         rst = (c != 1);
         st  = (c == 1) ? 16'd1 : (c == 5) ? 16'd2 : 16'd0;
         case (c)
            0:       e = mk(0, 5'b00000, hold);
            1:       e = mk(2, 5'b10001, 8'h66);
            2, 3, 4: e = mk(0, 5'b00000, 8'h00);
            5:       e = mk(2, 5'b10001, 8'h33);
            6:       e = mk(0, 5'b10001, 8'h33);
            7:       e = mk(0, 5'b10101, 8'h33);
            default: e = mk(0, 5'b00000, 8'h33);
         endcase
         run_cycle(c == 0 || c == 4, 1'b1, (c < 4) ? 8'h66 : 8'h33, st, o);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid cycle %0d: got 0x%h expected 0x%h", c, o, e);
         end
      end
      rst  = 1'b1;
      hold = 8'h33;
   endtask

   task automatic test_stale_done();
      obs_t o, e;
      int n_latch = 0;
      for (int c = 0; c < 8; c++) begin
         if (c == 0)      e = mk(0, 5'b00000, hold);
         else if (c == 1) e = mk(1, 5'b11001, 8'h77);
         else if (c <= 5) e = mk(0, 5'b10001, 8'h77);
         else if (c == 6) e = mk(0, 5'b10101, 8'h77);
         else             e = mk(0, 5'b00000, 8'h77);
         run_cycle(c == 0, 1'b0, 8'h77, (c >= 1 && c <= 4) ? 16'd2 : 16'd0, o);
         if (o[11]) n_latch++;
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL stale_done cycle %0d: got 0x%h expected 0x%h", c, o, e);
         end
      end
      n_checks++;
      if (n_latch !== 1) begin
         n_fail++;
         $display("FAIL stale_done latch count: got %0d expected 1", n_latch);
      end
      hold = 8'h77;
   endtask

   // Reference: phase 0..3 = idle/request/release/finish; a transaction may spend at most
   // TO counted cycles per budget window, the budget restarting when it is exhausted.
   task automatic test_random();
      obs_t o, e;
      int ph = 0, waited = 0, mode = 0, r;
      logic m_op = 1'b0, m_timed = 1'b0, cv, op, to_hit;
      logic [7:0]  m_ret = hold, rv;
      logic [15:0] st;
      for (int c = 0; c < 3000; c++) begin
         if (c % 60 == 0) mode = $urandom_range(0, 2);
         rst = ($urandom_range(0, 199) != 0);
         cv  = ($urandom_range(0, 3) == 0);
         op  = 1'($urandom);
         rv  = 8'($urandom);
         r   = $urandom_range(0, 99);
         if (mode == 1) st = (r < 90) ? 16'd1 : (r < 95) ? 16'd2 : 16'd0;
         else           st = (r < 30) ? 16'd0 : (r < 60) ? 16'd1 : (r < 90) ? 16'd2
                             : 16'($urandom_range(3, 65535));
         e = mk((ph == 1) ? (m_op ? 2 : 1) : 0,
                {ph != 0, ph == 1 && !m_op && st == 16'd2, ph == 3, ph == 3 && m_timed, ph != 0},
                m_ret);
         run_cycle(cv, op, rv, st, o);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL random cycle %0d: got 0x%h expected 0x%h", c, o, e);
         end
         to_hit = (TO != 0) && ((waited % TO) == TO - 1);
         if (!rst) begin
            ph = 0; m_ret = 8'h00; m_op = 1'b0; m_timed = 1'b0; waited = 0;
         end else begin
            case (ph)
               0: if (cv) begin
                     ph = 1; m_op = op; m_ret = rv; m_timed = 1'b0; waited = 0;
                  end
               1: if (st == 16'd2) ph = 2;
                  else begin
                     if (to_hit) begin m_timed = 1'b1; ph = 2; end
                     waited++;
                  end
               2: begin
                     if (st == 16'd0) ph = 3;
                     else if (to_hit) begin m_timed = 1'b1; ph = 3; end
                     waited++;
                  end
               default: ph = 0;
            endcase
         end
      end
      rst = 1'b1;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.call_valid = 1'b0;
      bus.call_op    = 1'b0;
      bus.call_ret   = '0;
      bus.mobo_stat  = '0;
      rst            = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_read_happy();
      test_write_slow();
      test_timeout();
      test_release_timeout();
      test_busy_reject();
      test_reset_mid();
      test_stale_done();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
